// File: rtl/data_mem_responder.sv
// data_mem_responder: single-port 32-bit data memory behind a fixed-latency
// request/response handshake, intended to sit on a CPU's MEM stage.
// A request is accepted only in IDLE, waits LATENCY cycles in WAIT,
// then the access happens and a one-cycle resp_valid pulse follows in RESP.
// Optional feature: define DMEM_BOUNDS_CHECK_EN to add an err output that
// flags misaligned or out-of-range addresses and suppresses the access.
module data_mem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] rdata,
    output logic        busy
`ifdef DMEM_BOUNDS_CHECK_EN
    ,
    output logic        err
`endif
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t          state;
    logic [3:0]      cnt;

    // Request fields captured at acceptance; data path, no reset needed.
    logic            write_p0;
    logic [AW-1:0]   idx_p0;
    logic [31:0]     wdata_p0;
    logic            bad_p0;

    logic [31:0]     mem [DEPTH];

    logic            accept;
    logic            access;
    logic            bad_req;

`ifdef DMEM_BOUNDS_CHECK_EN
    // Any byte offset or any address bit above the index range is an error.
    assign bad_req = (|addr[31:AW+2]) | (|addr[1:0]);
`else
    // Without checking, offset and upper address bits are simply dropped
    // so the word index wraps modulo DEPTH.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr[31:AW+2], addr[1:0]};
    assign bad_req          = 1'b0;
`endif

    // Ready is gated by reset so nothing is offered while rst is low, yet a
    // request can still be taken on the very first edge after release.
    assign req_ready = rst && (state == IDLE);
    assign accept    = (state == IDLE) && req_valid;
    assign access    = (state == WAIT) && (cnt == 4'd0);

    // Capture the request fields on acceptance.
    always_ff @(posedge clk) begin
        if (accept) begin
            write_p0 <= req_write;
            idx_p0   <= addr[AW+1:2];
            wdata_p0 <= wdata;
            bad_p0   <= bad_req;
        end
    end

    // Memory array write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (access && write_p0 && !bad_p0) begin
            mem[idx_p0] <= wdata_p0;
        end
    end

    // Handshake FSM with registered status outputs and load data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            rdata      <= 32'd0;
            resp_valid <= 1'b0;
            busy       <= 1'b0;
`ifdef DMEM_BOUNDS_CHECK_EN
            err        <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    resp_valid <= 1'b0;
                    if (req_valid) begin
                        state <= WAIT;
                        cnt   <= CNT_LOAD;
                        busy  <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        // Stores and flagged accesses both return zero.
                        rdata      <= (write_p0 || bad_p0) ? 32'd0 : mem[idx_p0];
`ifdef DMEM_BOUNDS_CHECK_EN
                        err        <= bad_p0;
`endif
                    end
                end
                RESP: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    busy       <= 1'b0;
`ifdef DMEM_BOUNDS_CHECK_EN
                    err        <= 1'b0;
`endif
                end
                default: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Testbench for data_mem_responder (DEPTH=256, LATENCY=2) with a word-array
// reference model. Works with or without DMEM_BOUNDS_CHECK_EN defined.
module tb_data_mem_responder;

    localparam int DEPTH = 256;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] rdata;
    logic        busy;
`ifdef DMEM_BOUNDS_CHECK_EN
    logic        err;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] ref_mem   [DEPTH];
    bit          ref_known [DEPTH];
    logic [31:0] last_rdata = 32'd0;

    data_mem_responder #(
        .DEPTH   (DEPTH),
        .LATENCY (LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .addr       (addr),
        .wdata      (wdata),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .rdata      (rdata),
        .busy       (busy)
`ifdef DMEM_BOUNDS_CHECK_EN
        ,
        .err        (err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic bit is_bad(input logic [31:0] a);
`ifdef DMEM_BOUNDS_CHECK_EN
        return (a[31:10] != 22'd0) || (a[1:0] != 2'd0);
`else
        return 1'b0;
`endif
    endfunction

    // One complete transaction, starting and ending at a falling edge in IDLE.
    // While the DUT is busy the inputs are filled with noise that must be ignored.
    task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d);
        int          idx;
        bit          bad;
        bit          chk;
        logic [31:0] exp;
        idx = int'(a[9:2]);
        bad = is_bad(a);
        chk = 1'b1;
        exp = 32'd0;
        if (w) begin
            if (!bad) begin
                ref_mem[idx]   = d;
                ref_known[idx] = 1'b1;
            end
        end else if (!bad) begin
            exp = ref_mem[idx];
            chk = ref_known[idx];
        end
        req_valid = 1'b1;
        req_write = w;
        addr      = a;
        wdata     = d;
        #1;
        check_val("ready_idle", req_ready, 32'd1);
        @(negedge clk);
        for (int k = 1; k <= LAT; k++) begin
            check_val("wait_resp", resp_valid, 32'd0);
            check_val("wait_busy", busy, 32'd1);
            check_val("wait_ready", req_ready, 32'd0);
            check_val("wait_rdata_hold", rdata, last_rdata);
            req_valid = 1'($urandom);
            req_write = 1'($urandom);
            addr      = $urandom;
            wdata     = $urandom;
            @(negedge clk);
        end
        check_val("resp_valid", resp_valid, 32'd1);
        check_val("resp_busy", busy, 32'd1);
        if (chk) check_val(w ? "store_rdata" : "load_rdata", rdata, exp);
`ifdef DMEM_BOUNDS_CHECK_EN
        check_val("resp_err", err, 32'(bad));
`endif
        last_rdata = rdata;
        req_valid  = 1'b0;
        @(negedge clk);
        check_val("post_resp", resp_valid, 32'd0);
        check_val("post_busy", busy, 32'd0);
        check_val("post_ready", req_ready, 32'd1);
        check_val("post_rdata_hold", rdata, last_rdata);
`ifdef DMEM_BOUNDS_CHECK_EN
        check_val("post_err", err, 32'd0);
`endif
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_known[i] = 1'b0;

        // Reset state, with a request presented that must not be taken.
        req_valid = 1'b1;
        #1;
        check_val("rst_ready", req_ready, 32'd0);
        check_val("rst_busy", busy, 32'd0);
        check_val("rst_resp", resp_valid, 32'd0);
        check_val("rst_rdata", rdata, 32'd0);
        repeat (3) @(negedge clk);
        check_val("rst_busy_hold", busy, 32'd0);
        check_val("rst_ready_hold", req_ready, 32'd0);

        // Release and accept on the very first edge; then store/load pair.
        rst = 1'b1;
        do_req(1'b1, 32'h10, 32'hDEADBEEF);
        do_req(1'b0, 32'h10, 32'h0);

        // Fill every word so later loads have known expectations.
        for (int i = 0; i < DEPTH; i++) do_req(1'b1, 32'(i * 4), $urandom);

        // Wrap-around / bounds behaviour on word 0.
        do_req(1'b1, 32'h400, 32'h12345678);
        do_req(1'b0, 32'h000, 32'h0);
        do_req(1'b0, 32'h402, 32'h0);

        // Reset while a store is waiting: store must be abandoned.
        do_req(1'b1, 32'h20, 32'h11111111);
        req_valid = 1'b1;
        req_write = 1'b1;
        addr      = 32'h20;
        wdata     = 32'hAAAA5555;
        @(negedge clk);
        check_val("abort_busy_before", busy, 32'd1);
        rst = 1'b0;
        req_valid = 1'b0;
        #1;
        check_val("abort_busy", busy, 32'd0);
        check_val("abort_ready", req_ready, 32'd0);
        check_val("abort_resp", resp_valid, 32'd0);
        check_val("abort_rdata", rdata, 32'd0);
        last_rdata = 32'd0;
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_val("abort_no_resp", resp_valid, 32'd0);
        end
        do_req(1'b0, 32'h20, 32'h0);

        // Held req_valid: four loads, one pulse every LAT+2 cycles.
        req_valid = 1'b1;
        req_write = 1'b0;
        addr      = 32'h40;
        for (int k = 1; k <= 4 * (LAT + 2) - 1; k++) begin
            @(negedge clk);
            check_val("held_resp", resp_valid, 32'((k % (LAT + 2)) == LAT + 1));
            check_val("held_ready", req_ready, 32'((k % (LAT + 2)) == 0));
            if ((k % (LAT + 2)) == LAT + 1) check_val("held_rdata", rdata, ref_mem[16]);
        end
        req_valid = 1'b0;
        @(negedge clk);
        check_val("held_end_ready", req_ready, 32'd1);
        check_val("held_end_resp", resp_valid, 32'd0);
        last_rdata = rdata;

        // Randomized mix of loads and stores, mostly in range.
        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            if ($urandom_range(0, 3) != 0) a = {22'd0, 8'($urandom), 2'd0};
            else a = $urandom;
            do_req(1'($urandom), a, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
